amo_reservation_unit: RTL and testbench

- Shared atomic-memory-operation support block. It sits beside the load/store sub-units (local memory, data cache, bus) and serves all of them.
- Owns the single hart LR/SC reservation: address, owning sub-unit and optional expiry.
- Provides the combinational read-modify-write ALU that a sub-unit uses during its RMW write-back cycle.
- Each sub-unit drives set/clear/address and RMW operands into this block; this block returns reservation_valid and rd.

---
 rtl/amo_reservation_unit_if.sv | 30 +++
 rtl/amo_reservation_unit.sv | 144 ++++++++++++++
 tb/tb_amo_reservation_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/amo_reservation_unit_if.sv
// Bundle between the load/store sub-units and amo_reservation_unit.
// Each client drives one slice of every per-unit vector; rd/valid/conflict are returned.
interface amo_reservation_unit_if #(
    parameter int NUM_UNITS = 2
);
    // No backpressure: set/clear act on the edge they are seen, and rmw_valid
    // qualifies rmw_op/rmw_rs1/rmw_rs2 for that same cycle only (rd is combinational).
    logic [NUM_UNITS-1:0]      set_reservation;
    logic [NUM_UNITS-1:0]      clear_reservation;
    logic [NUM_UNITS*32-1:0]   reservation_addr;
    logic [NUM_UNITS-1:0]      reservation_valid;
    logic [NUM_UNITS-1:0]      rmw_valid;
    logic [NUM_UNITS*5-1:0]    rmw_op;
    logic [NUM_UNITS*32-1:0]   rmw_rs1;
    logic [NUM_UNITS*32-1:0]   rmw_rs2;
    logic [31:0]               rd;
    logic                      rmw_conflict;

    modport master (
        output set_reservation, clear_reservation, reservation_addr,
        output rmw_valid, rmw_op, rmw_rs1, rmw_rs2,
        input  reservation_valid, rd, rmw_conflict
    );

    modport slave (
        input  set_reservation, clear_reservation, reservation_addr,
        input  rmw_valid, rmw_op, rmw_rs1, rmw_rs2,
        output reservation_valid, rd, rmw_conflict
    );
endinterface

// File: rtl/amo_reservation_unit.sv
// Single-hart LR/SC reservation plus shared combinational AMO read-modify-write ALU.
// Optional reservation expiry is enabled with the macro AMO_RES_TIMEOUT_EN.
module amo_reservation_unit #(
    parameter int NUM_UNITS           = 2,
    parameter int RESERVATION_TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst,
    amo_reservation_unit_if.slave bus
);
    localparam int OW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic          res_valid;
    logic [29:0]   res_addr;
    logic [OW-1:0] res_owner;
    logic          conflict;

    logic          any_set;
    logic          any_clr;
    logic [OW-1:0] set_idx;
    logic [29:0]   set_addr;
    logic          expired;

    // Scan high-to-low so the lowest requesting unit is the last writer.
    always_comb begin
        any_set  = 1'b0;
        set_idx  = '0;
        set_addr = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (bus.set_reservation[i]) begin
                any_set  = 1'b1;
                set_idx  = OW'(i);
                set_addr = bus.reservation_addr[32*i+2 +: 30];
            end
        end
    end

    assign any_clr = |bus.clear_reservation;

`ifdef AMO_RES_TIMEOUT_EN
    localparam int CW = $clog2(RESERVATION_TIMEOUT + 1);
    logic [CW-1:0] res_cnt;

    assign expired = res_valid && (res_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (any_set) begin
            res_cnt <= CW'(RESERVATION_TIMEOUT);
        end else if (res_valid && (res_cnt != '0)) begin
            res_cnt <= res_cnt - CW'(1);
        end
    end
`else
    logic unused_timeout;
    assign expired        = 1'b0;
    assign unused_timeout = (RESERVATION_TIMEOUT != 0);
`endif

    // A set outranks a clear so an LR that also raises its own clear still reserves.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_addr  <= '0;
            res_owner <= '0;
        end else if (any_set) begin
            res_valid <= 1'b1;
            res_addr  <= set_addr;
            res_owner <= set_idx;
        end else if (any_clr || expired) begin
            res_valid <= 1'b0;
        end
    end

    // Registered state only, so an SC issued alongside its clear sees the old value.
    always_comb begin
        bus.reservation_valid = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            bus.reservation_valid[i] = res_valid && (res_owner == OW'(i)) &&
                                       (res_addr == bus.reservation_addr[32*i+2 +: 30]);
        end
    end

    logic [1:0] unused_addr_lsbs;
    always_comb begin
        unused_addr_lsbs = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unused_addr_lsbs = unused_addr_lsbs ^ bus.reservation_addr[32*i +: 2];
        end
    end

    logic        any_rmw;
    logic [4:0]  op_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rmw_count;

    always_comb begin
        any_rmw   = 1'b0;
        op_sel    = '0;
        a         = '0;
        b         = '0;
        rmw_count = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            rmw_count = rmw_count + 3'(bus.rmw_valid[i]);
            if (bus.rmw_valid[i]) begin
                any_rmw = 1'b1;
                op_sel  = bus.rmw_op[5*i +: 5];
                a       = bus.rmw_rs1[32*i +: 32];
                b       = bus.rmw_rs2[32*i +: 32];
            end
        end
    end

    // Min/max pick rs2 only on strict inequality, so equal operands return rs1.
    always_comb begin
        bus.rd = '0;
        if (any_rmw) begin
            case (op_sel)
                5'b00001: bus.rd = b;
                5'b00000: bus.rd = a + b;
                5'b00100: bus.rd = a ^ b;
                5'b01100: bus.rd = a & b;
                5'b01000: bus.rd = a | b;
                5'b10000: bus.rd = ($signed(b) < $signed(a)) ? b : a;
                5'b10100: bus.rd = ($signed(b) > $signed(a)) ? b : a;
                5'b11000: bus.rd = (b < a) ? b : a;
                5'b11100: bus.rd = (b > a) ? b : a;
                default:  bus.rd = a;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict <= 1'b0;
        end else if (rmw_count > 3'd1) begin
            conflict <= 1'b1;
        end
    end

    assign bus.rmw_conflict = conflict;
endmodule

// File: tb/tb_amo_reservation_unit.sv
// Self-checking bench for amo_reservation_unit: directed steps, then random traffic
// compared against a behavioural reservation/ALU model.
module tb_amo_reservation_unit;
  localparam int NU = 2;
  localparam int T  = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  amo_reservation_unit_if #(.NUM_UNITS(NU)) bus ();

  amo_reservation_unit #(.NUM_UNITS(NU), .RESERVATION_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus variables ----------------
  logic [NU-1:0] b_set, b_clr, b_rv;
  logic [31:0]   b_addr [NU];
  logic [4:0]    b_op   [NU];
  logic [31:0]   b_rs1  [NU];
  logic [31:0]   b_rs2  [NU];

  assign bus.set_reservation   = b_set;
  assign bus.clear_reservation = b_clr;
  assign bus.rmw_valid         = b_rv;
  assign bus.reservation_addr  = {b_addr[1], b_addr[0]};
  assign bus.rmw_op            = {b_op[1], b_op[0]};
  assign bus.rmw_rs1           = {b_rs1[1], b_rs1[0]};
  assign bus.rmw_rs2           = {b_rs2[1], b_rs2[0]};

  // ---------------- reference model ----------------
  bit          m_valid;
  logic [31:0] m_addr;
  int          m_owner;
  int          m_age;
  bit          m_conflict;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_alu(logic [4:0] op, logic [31:0] x, logic [31:0] y);
    int sx = x;
    int sy = y;
    case (op)
      5'd1:  return y;
      5'd0:  return x + y;
      5'd4:  return x ^ y;
      5'd12: return x & y;
      5'd8:  return x | y;
      5'd16: return (sy < sx) ? y : x;
      5'd20: return (sy > sx) ? y : x;
      5'd24: return (y < x) ? y : x;
      5'd28: return (y > x) ? y : x;
      default: return x;
    endcase
  endfunction

  function automatic logic [NU-1:0] ref_valid();
    logic [NU-1:0] v = '0;
    for (int i = 0; i < NU; i++)
      v[i] = m_valid && (m_owner == i) && ((b_addr[i] >> 2) == (m_addr >> 2));
    return v;
  endfunction

  function automatic logic [31:0] ref_rd();
    for (int i = 0; i < NU; i++)
      if (b_rv[i]) return ref_alu(b_op[i], b_rs1[i], b_rs2[i]);
    return 32'h0;
  endfunction

  // Advance the model by one clock edge using the inputs held during that cycle.
  task automatic model_edge();
    int first = -1;
    for (int i = NU - 1; i >= 0; i--) if (b_set[i]) first = i;
    if (rst) begin
      m_valid = 0; m_addr = 0; m_owner = 0; m_age = 0; m_conflict = 0;
    end else begin
      if ($countones(b_rv) > 1) m_conflict = 1;
      if (first >= 0) begin
        m_valid = 1; m_addr = b_addr[first]; m_owner = first; m_age = 0;
      end else if (b_clr != '0) begin
        m_valid = 0;
      end else begin
`ifdef AMO_RES_TIMEOUT_EN
        if (m_valid && m_age >= T) m_valid = 0;
`endif
        m_age++;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the current cycle against the model, then take one clock edge.
  task automatic cycle(string tag);
    #2;
    exp_q.push_back(32'(ref_valid()));
    exp_q.push_back(ref_rd());
    exp_q.push_back(32'(m_conflict));
    chk({tag, "/valid"},    32'(bus.reservation_valid), exp_q.pop_front());
    chk({tag, "/rd"},       bus.rd,                     exp_q.pop_front());
    chk({tag, "/conflict"}, 32'(bus.rmw_conflict),      exp_q.pop_front());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    b_set = '0; b_clr = '0; b_rv = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;
  endtask

  // ---------------- directed steps then random ----------------
  logic [4:0] ops [12] = '{5'd1, 5'd0, 5'd4, 5'd12, 5'd8, 5'd16, 5'd20, 5'd24, 5'd28, 5'd2, 5'd3, 5'd31};

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < NU; i++) begin
      b_addr[i] = 0; b_op[i] = 0; b_rs1[i] = 0; b_rs2[i] = 0;
    end
    m_valid = 0; m_addr = 0; m_owner = 0; m_age = 0; m_conflict = 0;
    @(posedge clk); model_edge(); #1;
    do_reset();
    #1;
    chk("reset_valid",    32'(bus.reservation_valid), 32'h0);
    chk("reset_conflict", 32'(bus.rmw_conflict),      32'h0);
    chk("reset_rd",       bus.rd,                     32'h0);

    // Byte offset ignored, owner match required.
    b_set = 2'b01; b_addr[0] = 32'h0000_1004; b_addr[1] = 32'h0000_1004;
    cycle("set0");
    idle(); b_addr[0] = 32'h0000_1007;
    #1;
    chk("offset_match_v0", 32'(bus.reservation_valid[0]), 32'h1);
    chk("other_unit_v1",   32'(bus.reservation_valid[1]), 32'h0);
    cycle("offset");
    b_addr[0] = 32'h0000_1008;
    #1;
    chk("next_word_v0", 32'(bus.reservation_valid[0]), 32'h0);
    cycle("nextword");

    // Clear from another unit masks only from the following cycle.
    b_addr[0] = 32'h0000_1004;
    b_set = 2'b01;
    cycle("set0b");
    idle();
    cycle("hold");
    b_clr = 2'b10;
    #1;
    chk("clear_cycle_v0", 32'(bus.reservation_valid[0]), 32'h1);
    cycle("clear1");
    idle();
    #1;
    chk("after_clear_v0", 32'(bus.reservation_valid[0]), 32'h0);
    cycle("afterclr");

    // LR case: set and clear from the same unit.
    b_set = 2'b01; b_clr = 2'b01;
    cycle("setclr");
    idle();
    #1;
    chk("setclr_v0", 32'(bus.reservation_valid[0]), 32'h1);
    cycle("setclr_hold");

    // Simultaneous sets: lowest unit wins.
    b_set = 2'b11; b_addr[0] = 32'h100; b_addr[1] = 32'h200;
    cycle("dualset");
    idle();
    #1;
    chk("dual_v0", 32'(bus.reservation_valid[0]), 32'h1);
    chk("dual_v1", 32'(bus.reservation_valid[1]), 32'h0);
    b_addr[1] = 32'h100;
    #1;
    chk("dual_v1_sameaddr", 32'(bus.reservation_valid[1]), 32'h0);
    cycle("dual_hold");

    // RMW ALU through unit 1.
    b_rv = 2'b10; b_rs1[1] = 32'hFFFF_FFFE; b_rs2[1] = 32'h0000_0001;
    b_op[1] = 5'b10000; #1; chk("min",  bus.rd, 32'hFFFF_FFFE); cycle("min");
    b_op[1] = 5'b11000; #1; chk("minu", bus.rd, 32'h0000_0001); cycle("minu");
    b_op[1] = 5'b10100; #1; chk("max",  bus.rd, 32'h0000_0001); cycle("max");
    b_op[1] = 5'b11100; #1; chk("maxu", bus.rd, 32'hFFFF_FFFE); cycle("maxu");
    b_op[1] = 5'b00000; b_rs1[1] = 32'hFFFF_FFFF;
    #1; chk("add_wrap", bus.rd, 32'h0); cycle("add");
    b_op[1] = 5'b00001; #1; chk("swap", bus.rd, 32'h0000_0001); cycle("swap");
    b_op[1] = 5'b00010; #1; chk("lr_rs1", bus.rd, 32'hFFFF_FFFF); cycle("lr");
    b_op[1] = 5'b10000; b_rs2[1] = 32'hFFFF_FFFF;
    #1; chk("min_equal", bus.rd, 32'hFFFF_FFFF); cycle("mineq");
    idle();
    #1; chk("no_rmw_rd", bus.rd, 32'h0);
    chk("no_conflict_yet", 32'(bus.rmw_conflict), 32'h0);
    cycle("idle");

    // Two RMW requests: unit 0 serviced, sticky conflict.
    b_rv = 2'b11; b_op[0] = 5'b00000; b_rs1[0] = 1; b_rs2[0] = 2;
    b_op[1] = 5'b00100; b_rs1[1] = 32'hF0; b_rs2[1] = 32'h0F;
    #1; chk("conflict_rd", bus.rd, 32'h3);
    cycle("conflict");
    idle();
    for (int k = 0; k < 3; k++) begin
      #1; chk("conflict_sticky", 32'(bus.rmw_conflict), 32'h1);
      cycle("sticky");
    end

`ifdef AMO_RES_TIMEOUT_EN
    // Reservation lives T+1 cycles after its set edge; a re-set reloads.
    b_set = 2'b01; b_addr[0] = 32'h40;
    cycle("to_set");
    idle();
    for (int k = 0; k <= T; k++) begin
      #1; chk("to_alive", 32'(bus.reservation_valid[0]), 32'h1); cycle("to_alive");
    end
    #1; chk("to_expired", 32'(bus.reservation_valid[0]), 32'h0); cycle("to_exp");
    b_set = 2'b01;
    cycle("to_set2");
    idle(); cycle("to_w1"); cycle("to_w2");
    b_set = 2'b01;
    cycle("to_reset");
    idle();
    for (int k = 0; k <= T; k++) begin
      #1; chk("to_ext_alive", 32'(bus.reservation_valid[0]), 32'h1); cycle("to_ext");
    end
    #1; chk("to_ext_expired", 32'(bus.reservation_valid[0]), 32'h0); cycle("to_ext_exp");
`endif

    // Reset mid-operation drops the reservation and the conflict flag.
    b_set = 2'b01; b_addr[0] = 32'h80;
    cycle("pre_rst_set");
    idle();
    do_reset();
    #1;
    chk("rst_drops_res",      32'(bus.reservation_valid[0]), 32'h0);
    chk("rst_clears_conflict", 32'(bus.rmw_conflict),        32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NU; i++) begin
        b_set[i]  = ($urandom_range(0, 7) == 0);
        b_clr[i]  = ($urandom_range(0, 9) == 0);
        b_rv[i]   = ($urandom_range(0, 2) == 0);
        b_addr[i] = {28'h0000_100, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        b_op[i]   = ops[$urandom_range(0, 11)];
        b_rs1[i]  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        b_rs2[i]  = ($urandom_range(0, 3) == 0) ? b_rs1[i] : $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    idle();
    cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
